// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame parser: FSM states, the
// default frame start marker and the frame length.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        OPC  = 3'd1,
        DHI  = 3'd2,
        DLO  = 3'd3,
        CKS  = 3'd4
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // SYNC, opcode, data_hi, data_lo, checksum
    localparam int FRAME_LEN = 5;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of the receiver handshake and command outputs of uart_cmd_ctrl,
// so a source/consumer can be wired to the parser as one object.
interface uart_cmd_ctrl_if;

    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  opcode;
    logic [15:0] payload;
    logic        cksum_err;
    logic        timeout_err;
    logic        overrun_err;

    // master: the side feeding bytes and consuming commands
    modport master (
        output rx_rdy,
        output rx_data,
        output clr_cmd_rdy,
        input  clr_rx_rdy,
        input  cmd_rdy,
        input  opcode,
        input  payload,
        input  cksum_err,
        input  timeout_err,
        input  overrun_err
    );

    // slave: the frame parser
    modport slave (
        input  rx_rdy,
        input  rx_data,
        input  clr_cmd_rdy,
        output clr_rx_rdy,
        output cmd_rdy,
        output opcode,
        output payload,
        output cksum_err,
        output timeout_err,
        output overrun_err
    );

endinterface

// File: rtl/uart_cmd_ctrl.sv
// Parses 5-byte frames (SYNC, opcode, data_hi, data_lo, cksum) from a UART
// receiver and presents validated commands with a ready/acknowledge flag.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  opcode,
    output logic [15:0] payload,
    output logic        cksum_err,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int               CNT_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_clr_rx_rdy;

    logic [7:0]       r_shadow [3];
    logic [2:0]       w_shadow_ld;

    logic             r_cmd_rdy;
    logic [7:0]       r_opcode;
    logic [15:0]      r_payload;
    logic             r_cksum_err;
    logic             r_timeout_err;
    logic             r_overrun_err;

    logic             w_accept;
    logic [7:0]       w_sum;
    logic             w_frame_done;
    logic             w_frame_ok;
    logic             w_frame_bad;
    logic             w_timeout;

    // A byte presented while our clear pulse is still out is the same byte again.
    assign w_accept     = rx_rdy && !r_clr_rx_rdy;
    assign w_sum        = r_shadow[0] + r_shadow[1] + r_shadow[2] + rx_data;
    assign w_frame_done = w_accept && (r_state == CKS);
    assign w_frame_ok   = w_frame_done && (w_sum == 8'h00);
    assign w_frame_bad  = w_frame_done && (w_sum != 8'h00);
    assign w_timeout    = (r_state != SYNC) && !w_accept && (r_cnt == CNT_MAX);

    // Shadow byte gi is loaded when its frame position is being accepted.
    for (genvar gi = 0; gi < 3; gi++) begin : g_shadow_ld
        localparam state_t LD_STATE = state_t'(gi + 1);
        assign w_shadow_ld[gi] = w_accept && (r_state == LD_STATE);
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        if (w_accept) begin
            w_cnt_next = '0;
            case (r_state)
                SYNC:    w_state_next = (rx_data == SYNC_BYTE) ? OPC : SYNC;
                OPC:     w_state_next = DHI;
                DHI:     w_state_next = DLO;
                DLO:     w_state_next = CKS;
                CKS:     w_state_next = SYNC;
                default: w_state_next = SYNC;
            endcase
        end else if (r_state == SYNC) begin
            w_cnt_next = '0;
        end else if (w_timeout) begin
            w_state_next = SYNC;
            w_cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= SYNC;
            r_cnt        <= '0;
            r_clr_rx_rdy <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_clr_rx_rdy <= w_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_shadow_ld[i]) begin
                    r_shadow[i] <= rx_data;
                end
            end
        end
    end

    // A completing valid frame beats a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_rdy     <= 1'b0;
            r_opcode      <= '0;
            r_payload     <= '0;
            r_cksum_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_cksum_err   <= w_frame_bad;
            r_timeout_err <= w_timeout;
            r_overrun_err <= w_frame_ok && r_cmd_rdy;
            if (w_frame_ok) begin
                r_cmd_rdy <= 1'b1;
                r_opcode  <= r_shadow[0];
                r_payload <= {r_shadow[1], r_shadow[2]};
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign clr_rx_rdy  = r_clr_rx_rdy;
    assign cmd_rdy     = r_cmd_rdy;
    assign opcode      = r_opcode;
    assign payload     = r_payload;
    assign cksum_err   = r_cksum_err;
    assign timeout_err = r_timeout_err;
    assign overrun_err = r_overrun_err;

endmodule
